// File: rtl/fcore_alu_issue_scheduler_if.sv
// Decoded-op input handshake and registered issue bundle between the decode stage,
// the issue scheduler and the RF/ALU.
interface fcore_alu_issue_scheduler_if #(
    parameter int OPCODE_WIDTH        = 8,
    parameter int REGISTER_ADDR_WIDTH = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [OPCODE_WIDTH-1:0]        in_opcode;
    logic [REGISTER_ADDR_WIDTH-1:0] in_dest;
    logic [REGISTER_ADDR_WIDTH-1:0] in_src_a;
    logic [REGISTER_ADDR_WIDTH-1:0] in_src_b;
    logic                           in_uses_b;

    logic                           issue_valid;
    logic [OPCODE_WIDTH-1:0]        issue_opcode;
    logic [REGISTER_ADDR_WIDTH-1:0] issue_dest;
    logic [REGISTER_ADDR_WIDTH-1:0] issue_src_a;
    logic [REGISTER_ADDR_WIDTH-1:0] issue_src_b;

    modport slave (
        input  in_valid, in_opcode, in_dest, in_src_a, in_src_b, in_uses_b,
        output in_ready,
        output issue_valid, issue_opcode, issue_dest, issue_src_a, issue_src_b
    );

    modport master (
        output in_valid, in_opcode, in_dest, in_src_a, in_src_b, in_uses_b,
        input  in_ready,
        input  issue_valid, issue_opcode, issue_dest, issue_src_a, issue_src_b
    );
endinterface

// File: rtl/fcore_alu_issue_scheduler.sv
// Issue-stage sequencer for the fCore FP ALU: RAW hazard stall, registered issue, flush/drain.
// Optional FCORE_SCHED_STATS_EN adds saturating stall/issue counters.
module fcore_alu_issue_scheduler #(
    parameter int OPCODE_WIDTH        = 8,
    parameter int REGISTER_ADDR_WIDTH = 8,
    parameter int PIPELINE_LENGTH     = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    fcore_alu_issue_scheduler_if.slave      bus,
    input  logic                            flush,
    output logic                            busy,
    output logic                            drain_done,
    output logic [31:0]                     stall_count,
    output logic [31:0]                     issue_count
);
    localparam int L = PIPELINE_LENGTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                     state_reg, state_next;
    logic                           ready_en_reg;
    logic [L:0]                     slot_v_reg;
    logic [REGISTER_ADDR_WIDTH-1:0] slot_dest_reg [0:L];
    logic [L:0]                     match;
    logic                           hazard, ready, accept;

    logic                           issue_valid_reg;
    logic [OPCODE_WIDTH-1:0]        issue_opcode_reg;
    logic [REGISTER_ADDR_WIDTH-1:0] issue_dest_reg, issue_src_a_reg, issue_src_b_reg;
    logic                           drain_done_reg;

    genvar gi;
    generate
        for (gi = 0; gi <= L; gi++) begin : g_match
            assign match[gi] = slot_v_reg[gi] &&
                               ((slot_dest_reg[gi] == bus.in_src_a) ||
                                (bus.in_uses_b && (slot_dest_reg[gi] == bus.in_src_b)));
        end
    endgenerate

    assign hazard = |match;
    // Flush wins over a same-cycle op, so ready drops combinationally with it.
    assign ready  = ready_en_reg && (state_reg != ST_DRAIN) && !hazard && !flush;
    assign accept = bus.in_valid && ready;
    assign busy   = (|slot_v_reg) || issue_valid_reg;

    assign bus.in_ready     = ready;
    assign bus.issue_valid  = issue_valid_reg;
    assign bus.issue_opcode = issue_opcode_reg;
    assign bus.issue_dest   = issue_dest_reg;
    assign bus.issue_src_a  = issue_src_a_reg;
    assign bus.issue_src_b  = issue_src_b_reg;
    assign drain_done       = drain_done_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_v_reg       <= '0;
            slot_dest_reg[0] <= '0;
        end else begin
            slot_v_reg       <= {slot_v_reg[L-1:0], accept};
            slot_dest_reg[0] <= bus.in_dest;
        end
    end

    generate
        for (gi = 1; gi <= L; gi++) begin : g_slot
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) slot_dest_reg[gi] <= '0;
                else        slot_dest_reg[gi] <= slot_dest_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (flush) state_next = ST_DRAIN;
                      else if (accept) state_next = ST_RUN;
            ST_RUN:   if (flush) state_next = ST_DRAIN;
                      else if (!busy && !accept) state_next = ST_IDLE;
            ST_DRAIN: if (!busy) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            ready_en_reg     <= 1'b0;
            drain_done_reg   <= 1'b0;
            issue_valid_reg  <= 1'b0;
            issue_opcode_reg <= '0;
            issue_dest_reg   <= '0;
            issue_src_a_reg  <= '0;
            issue_src_b_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            ready_en_reg    <= 1'b1;
            drain_done_reg  <= (state_reg == ST_DRAIN) && !busy;
            issue_valid_reg <= accept;
            if (accept) begin
                issue_opcode_reg <= bus.in_opcode;
                issue_dest_reg   <= bus.in_dest;
                issue_src_a_reg  <= bus.in_src_a;
                issue_src_b_reg  <= bus.in_src_b;
            end
        end
    end

`ifdef FCORE_SCHED_STATS_EN
    logic [31:0] stall_count_reg, issue_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
            issue_count_reg <= '0;
        end else begin
            if (bus.in_valid && !ready && (state_reg != ST_DRAIN) && (stall_count_reg != 32'hFFFF_FFFF))
                stall_count_reg <= stall_count_reg + 32'd1;
            if (issue_valid_reg && (issue_count_reg != 32'hFFFF_FFFF))
                issue_count_reg <= issue_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
    assign issue_count = issue_count_reg;
`else
    assign stall_count = '0;
    assign issue_count = '0;
`endif
endmodule

// File: tb/tb_fcore_alu_issue_scheduler.sv
// Randomised and directed bench for fcore_alu_issue_scheduler against a timestamp-queue model.
module tb_fcore_alu_issue_scheduler;
    localparam int L = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        busy, drain_done;
    logic [31:0] stall_count, issue_count;

    fcore_alu_issue_scheduler_if #(.OPCODE_WIDTH(8), .REGISTER_ADDR_WIDTH(8)) bus ();

    fcore_alu_issue_scheduler #(
        .OPCODE_WIDTH(8), .REGISTER_ADDR_WIDTH(8), .PIPELINE_LENGTH(L)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus.slave), .flush(flush),
        .busy(busy), .drain_done(drain_done),
        .stall_count(stall_count), .issue_count(issue_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted op is remembered with the cycle it was accepted in;
    // it is issued the next cycle and stays visible to hazard checks for L+1 cycles.
    typedef struct { int t; logic [7:0] d; } ent_t;
    ent_t        fl[$];
    int          cyc = 0;
    int          mst = 0;            // 0 idle, 1 run, 2 drain
    bit          m_ren = 0, m_iv = 0, m_dd = 0;
    logic [7:0]  m_op = 0, m_d = 0, m_a = 0, m_b = 0;
    logic [31:0] m_sc = 0, m_ic = 0;

    int          iss_cyc[$];
    logic [7:0]  iss_dest[$];
    int          dd_cyc[$];
    int          last_busy = 0;

    always @(negedge clock) begin : chk
        bit haz, bsy, exp_rdy, acc;
        if (!reset) begin
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_drain_done", 32'(drain_done), 32'd0);
            check("rst_issue_dest", 32'(bus.issue_dest), 32'd0);
            check("rst_stall_count", stall_count, 32'd0);
            check("rst_issue_count", issue_count, 32'd0);
            fl.delete();
            mst = 0; m_ren = 0; m_iv = 0; m_dd = 0;
            m_op = 0; m_d = 0; m_a = 0; m_b = 0; m_sc = 0; m_ic = 0;
        end else begin
            haz = 0; bsy = 0;
            foreach (fl[i]) begin
                if (cyc >= fl[i].t + 1 && cyc <= fl[i].t + L + 1) begin
                    bsy = 1;
                    if (fl[i].d == bus.in_src_a || (bus.in_uses_b && fl[i].d == bus.in_src_b)) haz = 1;
                end
            end
            exp_rdy = m_ren && (mst != 2) && !haz && !flush;
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(bsy));
            check("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
            check("issue_opcode", 32'(bus.issue_opcode), 32'(m_op));
            check("issue_dest", 32'(bus.issue_dest), 32'(m_d));
            check("issue_src_a", 32'(bus.issue_src_a), 32'(m_a));
            check("issue_src_b", 32'(bus.issue_src_b), 32'(m_b));
            check("drain_done", 32'(drain_done), 32'(m_dd));
`ifdef FCORE_SCHED_STATS_EN
            check("stall_count", stall_count, m_sc);
            check("issue_count", issue_count, m_ic);
`else
            check("stall_count_tied", stall_count, 32'd0);
            check("issue_count_tied", issue_count, 32'd0);
`endif
            acc = bus.in_valid && exp_rdy;
            if (bus.in_valid && !exp_rdy && mst != 2 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (m_iv && m_ic != 32'hFFFF_FFFF) m_ic = m_ic + 1;
            m_dd = (mst == 2) && !bsy;
            case (mst)
                0: if (flush) mst = 2; else if (acc) mst = 1;
                1: if (flush) mst = 2; else if (!bsy && !acc) mst = 0;
                default: if (!bsy) mst = 0;
            endcase
            m_iv = acc;
            if (acc) begin
                m_op = bus.in_opcode; m_d = bus.in_dest; m_a = bus.in_src_a; m_b = bus.in_src_b;
                fl.push_back('{t: cyc, d: bus.in_dest});
            end
            m_ren = 1;
            while (fl.size() > 0 && fl[0].t + L + 1 < cyc + 1) void'(fl.pop_front());
        end
        if (bus.issue_valid === 1'b1) begin
            iss_cyc.push_back(cyc);
            iss_dest.push_back(bus.issue_dest);
        end
        if (drain_done === 1'b1) dd_cyc.push_back(cyc);
        if (busy === 1'b1) last_busy = cyc;
        cyc++;
    end

    task automatic send(input logic [7:0] op, input logic [7:0] d, input logic [7:0] a,
                        input logic [7:0] b, input bit ub, output int stalls);
        bit r;
        bus.in_valid = 1; bus.in_opcode = op; bus.in_dest = d;
        bus.in_src_a = a; bus.in_src_b = b; bus.in_uses_b = ub;
        stalls = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock); r = bus.in_ready;
            @(posedge clock); #1;
            if (r) begin
                bus.in_valid = 0;
                return;
            end
            stalls++;
        end
        checks++; errors++;
        $display("FAIL send_timeout: op dest %0d never accepted within 60 cycles", d);
        bus.in_valid = 0;
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            quiet = busy ? 0 : quiet + 1;
            if (quiet >= 2) begin
                @(posedge clock); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy still %0b after 60 cycles, required 0", busy);
        @(posedge clock); #1;
    endtask

    initial begin
        int s1, s2, n0, nd0, hits;
        bit acc_s;
        bus.in_valid = 1; bus.in_opcode = 8'h01; bus.in_dest = 8'd1;
        bus.in_src_a = 8'd2; bus.in_src_b = 8'd3; bus.in_uses_b = 0;
        #1 reset = 0;

        // Test 1: reset with in_valid held high, then release
        repeat (3) @(posedge clock); #1;
        @(negedge clock);
        check("t1_ready_in_reset", 32'(bus.in_ready), 32'd0);
        check("t1_busy_in_reset", 32'(busy), 32'd0);
        @(posedge clock); #3 reset = 1;
        @(negedge clock);
        check("t1_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clock); #1;
        check("t1_ready_after_edge", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 0;
        @(posedge clock); #3 reset = 0;
        repeat (2) @(posedge clock); #3 reset = 1;
        @(posedge clock); #1;

        // Test 2: two independent ops back to back
        n0 = iss_cyc.size();
        send(8'h01, 8'd1, 8'd2, 8'd3, 0, s1);
        send(8'h03, 8'd4, 8'd5, 8'd6, 0, s2);
        wait_idle();
        check("t2_stall_first", 32'(s1), 32'd0);
        check("t2_stall_second", 32'(s2), 32'd0);
        check("t2_issue_cnt", 32'(iss_cyc.size() - n0), 32'd2);
        if (iss_cyc.size() - n0 == 2) check("t2_issue_gap", 32'(iss_cyc[n0+1] - iss_cyc[n0]), 32'd1);
`ifdef FCORE_SCHED_STATS_EN
        check("t2_issue_count", issue_count, 32'd2);
        check("t2_stall_count", stall_count, 32'd0);
`endif

        // Test 3: RAW hazard on source A
        n0 = iss_cyc.size();
        send(8'h01, 8'd1, 8'd2, 8'd3, 0, s1);
        send(8'h02, 8'd7, 8'd1, 8'd2, 0, s2);
        wait_idle();
        check("t3_raw_a_stalls", 32'(s2), 32'd6);
        if (iss_cyc.size() - n0 == 2) check("t3_issue_gap", 32'(iss_cyc[n0+1] - iss_cyc[n0]), 32'd7);
        else check("t3_issue_cnt", 32'(iss_cyc.size() - n0), 32'd2);
`ifdef FCORE_SCHED_STATS_EN
        check("t3_stall_count", stall_count, 32'd6);
        check("t3_issue_count", issue_count, 32'd4);
`endif

        // Test 4: RAW on source B, ignored then honoured
        send(8'h01, 8'd9, 8'd2, 8'd3, 0, s1);
        send(8'h04, 8'd10, 8'd11, 8'd9, 0, s2);
        wait_idle();
        check("t4_b_unused_stalls", 32'(s2), 32'd0);
        send(8'h01, 8'd9, 8'd2, 8'd3, 0, s1);
        send(8'h04, 8'd12, 8'd11, 8'd9, 1, s2);
        wait_idle();
        check("t4_b_used_stalls", 32'(s2), 32'd6);
`ifdef FCORE_SCHED_STATS_EN
        check("t4_stall_count", stall_count, 32'd12);
        check("t4_issue_count", issue_count, 32'd8);
`endif

        // Test 5: flush with three ops in flight
        send(8'h01, 8'd20, 8'd2, 8'd3, 0, s1);
        send(8'h01, 8'd21, 8'd2, 8'd3, 0, s1);
        send(8'h01, 8'd22, 8'd2, 8'd3, 0, s1);
        nd0 = dd_cyc.size();
        flush = 1;
        @(negedge clock);
        check("t5_flush_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clock); #1 flush = 0;
        repeat (20) @(posedge clock); #1;
        check("t5_drain_pulses", 32'(dd_cyc.size() - nd0), 32'd1);
        if (dd_cyc.size() - nd0 == 1) check("t5_drain_cycle", 32'(dd_cyc[nd0] - last_busy), 32'd2);
        send(8'h01, 8'd40, 8'd2, 8'd3, 0, s1);
        check("t5_reaccept_stalls", 32'(s1), 32'd0);
        wait_idle();

        // Test 6: flush coincident with in_valid, reset asserted during drain
        send(8'h01, 8'd50, 8'd2, 8'd3, 0, s1);
        send(8'h01, 8'd51, 8'd2, 8'd3, 0, s1);
        bus.in_valid = 1; bus.in_dest = 8'd60; flush = 1;
        @(negedge clock);
        check("t6_flush_vs_valid", 32'(bus.in_ready), 32'd0);
        @(posedge clock); #1 flush = 0; bus.in_valid = 0;
        #2 reset = 0;
        repeat (2) @(posedge clock); #3 reset = 1;
        nd0 = dd_cyc.size();
        repeat (8) @(posedge clock);
        @(negedge clock);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("t6_ready_after", 32'(bus.in_ready), 32'd1);
        check("t6_no_drain_done", 32'(dd_cyc.size() - nd0), 32'd0);
        hits = 0;
        foreach (iss_dest[i]) if (iss_dest[i] == 8'd60) hits++;
        check("t6_flushed_op_issued", 32'(hits), 32'd0);
        @(posedge clock); #1;

        // Random phase: small register pool for frequent hazards, occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock); acc_s = bus.in_valid && bus.in_ready;
            @(posedge clock); #1;
            flush = 0;
            if (!bus.in_valid || acc_s) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_opcode = 8'($urandom_range(0, 255));
                bus.in_dest   = 8'($urandom_range(0, 7));
                bus.in_src_a  = 8'($urandom_range(0, 7));
                bus.in_src_b  = 8'($urandom_range(0, 7));
                bus.in_uses_b = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 39) == 0) flush = 1;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 0;
                @(posedge clock); #3 reset = 1;
            end
        end
        bus.in_valid = 0; flush = 0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
